// File: rtl/sprite_loader_if.sv
// Byte-stream handshake between a byte source (e.g. UART RX) and the sprite loader.
interface sprite_loader_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/sprite_loader.sv
// Loads one SPR_W x SPR_H RGB565 sprite from a byte stream (high byte first) into
// on-chip RAM and serves the renderer's x/y pixel read port with 1-cycle latency.
module sprite_loader #(
  parameter int SPR_W = 20,
  parameter int SPR_H = 20,
  parameter int PIX_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  sprite_loader_if.slave       s,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic [4:0]           x_offset,
  input  logic [4:0]           y_offset,
  output logic [PIX_W-1:0]     pixel_data
);
  localparam int DEPTH = SPR_W * SPR_H;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD_HI = 2'd1,
    ST_LOAD_LO = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [AW-1:0]    addr_r;
  logic [7:0]       hi_r;
  logic             s_ready_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic [PIX_W-1:0] pix_r;
  logic [PIX_W-1:0] mem_r [DEPTH];

  logic             accept_s;
  logic             last_s;
  logic             wr_en_s;
  logic             err_s;
  logic             rd_in_range_s;
  logic [AW-1:0]    ra_s;

  // Next-state decode, write strobe and protocol-violation detection
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = s.s_valid & s_ready_r;
    last_s      = (addr_r == AW'(DEPTH - 1));
    wr_en_s     = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A byte offered while idle is refused and flagged, even alongside start.
        err_s = s.s_valid;
        if (start) begin
          state_nxt_s = ST_LOAD_HI;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD_HI: begin
        err_s = start;
        if (accept_s) begin
          state_nxt_s = ST_LOAD_LO;
        end else begin
          state_nxt_s = ST_LOAD_HI;
        end
      end
      ST_LOAD_LO: begin
        err_s = start;
        if (accept_s) begin
          wr_en_s = 1'b1;
          if (last_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_LOAD_HI;
          end
        end else begin
          state_nxt_s = ST_LOAD_LO;
        end
      end
      ST_DONE: begin
        err_s       = start;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        err_s       = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Read address at full address width; out-of-range offsets read as zero
  always_comb begin
    rd_in_range_s = (int'(x_offset) < SPR_W) && (int'(y_offset) < SPR_H);
    ra_s          = AW'(y_offset) * AW'(SPR_W) + AW'(x_offset);
  end

  // FSM state, address counter, high-byte holding register and registered status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      addr_r    <= {AW{1'b0}};
      hi_r      <= 8'h00;
      s_ready_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      s_ready_r <= (state_nxt_s == ST_LOAD_HI) || (state_nxt_s == ST_LOAD_LO);
      busy_r    <= (state_nxt_s != ST_IDLE);
      done_r    <= (state_nxt_s == ST_DONE);
      err_r     <= err_s;
      if ((state_r == ST_IDLE) && start) begin
        addr_r <= {AW{1'b0}};
      end else if (wr_en_s) begin
        addr_r <= last_s ? {AW{1'b0}} : (addr_r + AW'(1));
      end else begin
        addr_r <= addr_r;
      end
      if ((state_r == ST_LOAD_HI) && accept_s) begin
        hi_r <= s.s_data;
      end else begin
        hi_r <= hi_r;
      end
    end
  end

  // Sprite RAM write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[addr_r] <= PIX_W'({hi_r, s.s_data});
    end
  end

  // Registered read port; a same-cycle write to the same word returns the old data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_r <= {PIX_W{1'b0}};
    end else if (rd_in_range_s) begin
      pix_r <= mem_r[ra_s];
    end else begin
      pix_r <= {PIX_W{1'b0}};
    end
  end

  assign s.s_ready  = s_ready_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign pixel_data = pix_r;

endmodule

// File: tb/tb_sprite_loader.sv
// Self-checking bench for sprite_loader: table vectors, randomized-valid loads and
// a reference RAM image maintained per pixel index.
module tb_sprite_loader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        busy, done, err;
  logic [4:0]  x_off, y_off;
  logic [15:0] pixel_data;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [15:0] ref_mem [400];

  typedef struct {
    int          x;
    int          y;
    logic [15:0] exp;
  } rd_vec_t;
  rd_vec_t tbl [8];

  sprite_loader_if s_if ();
  assign s_if.s_valid = s_valid;
  assign s_if.s_data  = s_data;
  assign s_ready      = s_if.s_ready;

  sprite_loader #(.SPR_W(20), .SPR_H(20), .PIX_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .s          (s_if.slave),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .x_offset   (x_off),
    .y_offset   (y_off),
    .pixel_data (pixel_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pix_val(input int mode, input logic [15:0] base, input int i);
    case (mode)
      1:       return base;
      2:       return (i == 43) ? 16'hBEEF : base + 16'(i);
      default: return base + 16'(i);
    endcase
  endfunction

  function automatic logic [15:0] exp_rd(input int xi, input int yi);
    if (xi < 20 && yi < 20) return ref_mem[yi*20 + xi];
    else return 16'h0000;
  endfunction

  task automatic rd(input int xi, input int yi, input logic [15:0] e, input string nm);
    x_off = 5'(xi);
    y_off = 5'(yi);
    @(posedge clk); #1;
    check(nm, {16'h0000, pixel_data}, {16'h0000, e});
  endtask

  task automatic rd_all(input string nm);
    for (int yy = 0; yy < 20; yy++)
      for (int xx = 0; xx < 20; xx++)
        rd(xx, yy, exp_rd(xx, yy), nm);
  endtask

  // Called at #1 after an edge with the DUT idle. Streams 800 bytes; optional hooks:
  // inj_lo: pulse start while waiting for that pixel's low byte; inj_done: pulse start in DONE;
  // vws: offer a junk byte with start; rd_pix: read that pixel on its write cycle;
  // abort_pix: reset after that many pixels.
  task automatic load(input int mode, input logic [15:0] base, input int vprob,
                      input int inj_lo, input bit inj_done, input bit vws,
                      input int rd_pix, input int abort_pix);
    int idx = 0;
    int cyc = 0;
    int bad = 0;
    bit acc, stv, exp_err, injected, chk_old, chk_new, aborted, was_inj;
    logic [15:0] pv, old_v;
    injected = 0; chk_old = 0; chk_new = 0; aborted = 0; was_inj = 0;
    start = 1'b1; s_valid = vws; s_data = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_err", {31'd0, err}, {31'd0, vws});
    check("start_ready", {31'd0, s_ready}, 32'd1);
    exp_err = vws;
    while (idx < 800 && cyc < 6000) begin
      if (abort_pix > 0 && idx == 2*abort_pix) begin
        rst_n = 1'b0; s_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ready", {31'd0, s_ready}, 32'd0);
        check("abort_pix", {16'h0000, pixel_data}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < abort_pix; i++) ref_mem[i] = pix_val(mode, base, i);
        aborted = 1;
        break;
      end
      if (was_inj) begin check("err_lo", {31'd0, err}, 32'd1); was_inj = 0; end
      if (chk_new) begin
        check("rw_new", {16'h0000, pixel_data}, {16'h0000, pix_val(mode, base, rd_pix)});
        chk_new = 0;
      end
      if (chk_old) begin
        check("rw_old", {16'h0000, pixel_data}, {16'h0000, old_v});
        chk_old = 0; chk_new = 1;
      end
      if (s_ready !== 1'b1 || busy !== 1'b1) bad++;
      if (err !== exp_err) bad++;
      if (done !== 1'b0) bad++;
      exp_err = 0;
      stv = ($urandom_range(99) < vprob);
      pv = pix_val(mode, base, idx/2);
      s_valid = stv;
      s_data = (idx % 2 == 1) ? pv[7:0] : pv[15:8];
      if (inj_lo >= 0 && !injected && (idx % 2 == 1) && idx/2 == inj_lo) begin
        start = 1'b1; injected = 1; exp_err = 1; was_inj = 1;
      end
      if (rd_pix >= 0 && stv && idx == 2*rd_pix + 1) begin
        x_off = 5'(rd_pix % 20); y_off = 5'(rd_pix / 20);
        old_v = ref_mem[rd_pix]; chk_old = 1;
      end
      acc = stv && (s_ready === 1'b1);
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) idx++;
      cyc++;
    end
    s_valid = 1'b0;
    if (!aborted) begin
      check("load_timeout", 32'(cyc < 6000), 32'd1);
      check("stream_flags", 32'(bad), 32'd0);
      check("done_pulse", {31'd0, done}, 32'd1);
      check("done_busy", {31'd0, busy}, 32'd1);
      check("done_ready", {31'd0, s_ready}, 32'd0);
      for (int i = 0; i < 400; i++) ref_mem[i] = pix_val(mode, base, i);
      if (inj_done) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("post_err", {31'd0, err}, {31'd0, inj_done});
      check("post_done", {31'd0, done}, 32'd0);
      check("post_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      check("idle_ready", {31'd0, s_ready}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_err", {31'd0, err}, 32'd0);
    end
  endtask

  initial begin
    int d0;
    tbl[0] = '{0,  0,  16'hA000};
    tbl[1] = '{19, 19, 16'hA18F};
    tbl[2] = '{20, 0,  16'h0000};
    tbl[3] = '{0,  25, 16'h0000};
    tbl[4] = '{5,  3,  16'hA041};
    tbl[5] = '{31, 31, 16'h0000};
    tbl[6] = '{19, 0,  16'hA013};
    tbl[7] = '{0,  19, 16'hA17C};
    for (int i = 0; i < 400; i++) ref_mem[i] = 16'h0000;

    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00; x_off = 5'd0; y_off = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, s_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_pix", {16'h0000, pixel_data}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Contiguous load of A000+i
    d0 = done_cnt;
    load(0, 16'hA000, 100, -1, 0, 0, -1, 0);
    check("done_once", 32'(done_cnt - d0), 32'd1);
    for (int i = 0; i < 8; i++) rd(tbl[i].x, tbl[i].y, tbl[i].exp, "tbl_rd");
    rd_all("rd_all_1");

    // s_valid while idle: refused and flagged every cycle
    s_valid = 1'b1; s_data = 8'h55;
    @(posedge clk); #1;
    check("idle_v_err1", {31'd0, err}, 32'd1);
    check("idle_v_rdy", {31'd0, s_ready}, 32'd0);
    @(posedge clk); #1;
    check("idle_v_err2", {31'd0, err}, 32'd1);
    s_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_v_err3", {31'd0, err}, 32'd0);

    // Random stalls, start with a byte, start in LOAD_LO and in DONE
    for (int i = 0; i < 400; i++) ref_mem[i] = 16'h0000;
    d0 = done_cnt;
    load(0, 16'hA000, 50, 201, 1, 1, -1, 0);
    check("done_once_2", 32'(done_cnt - d0), 32'd1);
    rd_all("rd_all_2");

    // Read-first collision at pixel 43 = (3,2)
    load(2, 16'hA000, 100, -1, 0, 0, 43, 0);
    rd(3, 2, 16'hBEEF, "rw_after");
    rd(4, 2, 16'hA02C, "rw_neigh");

    // Reset after 100 pixels of C000+i, then a full reload of 1234
    load(0, 16'hC000, 100, -1, 0, 0, -1, 100);
    rd(10, 2, 16'hC032, "kept_50");
    rd(0, 5, 16'hA064, "kept_100");
    d0 = done_cnt;
    load(1, 16'h1234, 100, -1, 0, 0, -1, 0);
    check("done_once_6", 32'(done_cnt - d0), 32'd1);
    rd_all("rd_all_6");

    for (int i = 0; i < 150; i++) begin
      int xi, yi;
      xi = $urandom_range(31);
      yi = $urandom_range(31);
      rd(xi, yi, exp_rd(xi, yi), "rd_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
